des_iter_ctrl: RTL and testbench

//  Iterative DES engine controller. Sequences one shared combinational round function f(R,K) over 16 cycles
//  per block, replacing the fully unrolled Encrypt/decrypt pair. Owns IP/FP, PC1/PC2, the C/D key-schedule

---
 rtl/des_iter_ctrl_if.sv | 27 ++
 rtl/des_iter_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_des_iter_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/des_iter_ctrl_if.sv
// Host block stream, result stream and f-function hookup for the iterative DES controller.
// The controller connects through the slave modport; the host/f-function side uses master.
`timescale 1ns/1ps
interface des_iter_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        in_decrypt;
    logic [31:0] f_r;
    logic [47:0] f_k;
    logic [31:0] f_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, in_key, in_decrypt, f_out, out_ready,
        input  in_ready, f_r, f_k, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, f_out, out_ready,
        output in_ready, f_r, f_k, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one external f(R,K) shared over 16 rounds per block.
// Optional feature macro DES_DECRYPT_EN: when defined, in_decrypt selects right-rotating key schedule.
`timescale 1ns/1ps
module des_iter_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic           clk,
    input  logic           rst,
    des_iter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Permutation tables in DES numbering: output bit k (1-based, MSB first) takes input bit T[k].
    localparam logic [6:0] IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam logic [6:0] FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam logic [6:0] PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam logic [6:0] PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
        return y;
    endfunction

    // Parity bits (8,16,..,64) never appear in PC1, so they drop out here.
    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
        return y;
    endfunction

    function automatic logic [1:0] shift_amt(input logic [4:0] i);
        logic [1:0] a;
        case (i)
            5'd1, 5'd2, 5'd9, 5'd16: a = 2'd1;
            default:                 a = 2'd2;
        endcase
        return a;
    endfunction

    function automatic logic [27:0] rot_l(input logic [27:0] v, input logic [1:0] a);
        logic [27:0] y;
        case (a)
            2'd1:    y = {v[26:0], v[27]};
            2'd2:    y = {v[25:0], v[27:26]};
            default: y = v;
        endcase
        return y;
    endfunction

`ifdef DES_DECRYPT_EN
    function automatic logic [27:0] rot_r(input logic [27:0] v, input logic [1:0] a);
        logic [27:0] y;
        case (a)
            2'd1:    y = {v[0], v[27:1]};
            2'd2:    y = {v[1:0], v[27:2]};
            default: y = v;
        endcase
        return y;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [4:0]  rnd_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [27:0] c_nxt, d_nxt;
    logic        accept;
    logic        last_rnd;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_rnd = (rnd_q == 5'(ROUNDS));

`ifdef DES_DECRYPT_EN
    logic       mode_q;
    logic [1:0] dec_amt;

    // Decrypt walks K16..K1: round 1 uses the unrotated PC1 value, then undoes the encrypt shifts.
    assign dec_amt = (rnd_q == 5'd1) ? 2'd0 : shift_amt(5'(18 - rnd_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (accept) begin
            mode_q <= bus.in_decrypt;
        end
    end

    always_comb begin
        c_nxt = rot_l(c_q, shift_amt(rnd_q));
        d_nxt = rot_l(d_q, shift_amt(rnd_q));
        if (mode_q) begin
            c_nxt = rot_r(c_q, dec_amt);
            d_nxt = rot_r(d_q, dec_amt);
        end
    end
`else
    logic unused_in_decrypt;
    assign unused_in_decrypt = bus.in_decrypt;

    always_comb begin
        c_nxt = rot_l(c_q, shift_amt(rnd_q));
        d_nxt = rot_l(d_q, shift_amt(rnd_q));
    end
`endif

    // f operands come straight from the registers in every state, so they are defined after reset.
    assign bus.f_r      = r_q;
    assign bus.f_k      = perm_pc2({c_nxt, d_nxt});
    assign bus.out_data = perm_fp({r_q, l_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_d = ROUND;
            end
            ROUND: begin
                if (last_rnd) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q <= 5'd0;
            l_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
        end else if (accept) begin
            {l_q, r_q} <= perm_ip(bus.in_data);
            {c_q, d_q} <= perm_pc1(bus.in_key);
            rnd_q      <= 5'd1;
        end else if (state_q == ROUND) begin
            l_q <= r_q;
            r_q <= l_q ^ bus.f_out;
            c_q <= c_nxt;
            d_q <= d_nxt;
            // Counter parks at the last round; the final L/R swap is folded into out_data.
            if (!last_rnd) rnd_q <= rnd_q + 5'd1;
        end
    end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Directed bench for des_iter_ctrl: supplies a DES f-function and checks known-answer blocks,
// round subkeys, backpressure, back-to-back streaming and reset behaviour.
`timescale 1ns/1ps
module tb_des_iter_ctrl;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2  = 64'h8787878787878787;
    localparam logic [63:0] CT2  = 64'h0000000000000000;
    localparam logic [63:0] K1   = 64'h00001B02EFFC7072;
    localparam logic [63:0] K16  = 64'h0000CB3D8B0E17F5;
    localparam logic [63:0] R0   = 64'h00000000F0AAF0AA;

    localparam logic [5:0] E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam logic [5:0] P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam logic [3:0] SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        logic [5:0]  idx;
        e = '0;
        for (int i = 0; i < 48; i++) e = {e[46:0], r[5'(32 - E_T[i])]};
        x = e ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = 6'(x >> (42 - 6 * b));
            idx = {six[5], six[0], six[4:1]};
            s   = {s[27:0], SBOX[b][idx]};
        end
        p = '0;
        for (int i = 0; i < 32; i++) p = {p[30:0], s[5'(32 - P_T[i])]};
        return p;
    endfunction

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    des_iter_ctrl_if bus();

    des_iter_ctrl #(.ROUNDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.f_out = des_f(bus.f_r, bus.f_k);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one block for a single accept edge, then scrambles the inputs.
    task automatic offer(input logic [63:0] data, input logic [63:0] key, input logic dec);
        bus.in_valid   = 1'b1;
        bus.in_data    = data;
        bus.in_key     = key;
        bus.in_decrypt = dec;
        tick(1);
        bus.in_valid   = 1'b0;
        bus.in_data    = {$urandom, $urandom};
        bus.in_key     = {$urandom, $urandom};
        bus.in_decrypt = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_key     = '0;
        bus.in_decrypt = 1'b0;
        bus.out_ready  = 1'b0;
        tick(3);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        rst = 1'b0;
        tick(1);

        // Encrypt known answer with round trace, held in DONE by backpressure.
        offer(PT1, KEY1, 1'b0);
        check("enc_busy_r1", 64'(bus.busy), 64'd1);
        check("enc_in_ready_r1", 64'(bus.in_ready), 64'd0);
        check("enc_fk_r1", 64'(bus.f_k), K1);
        check("enc_fr_r1", 64'(bus.f_r), R0);
        tick(15);
        check("enc_fk_r16", 64'(bus.f_k), K16);
        check("enc_out_valid_r16", 64'(bus.out_valid), 64'd0);
        tick(1);
        check("enc_out_valid", 64'(bus.out_valid), 64'd1);
        check("enc_out_data", bus.out_data, CT1);

        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
            bus.in_key   = {$urandom, $urandom};
            tick(1);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_data", bus.out_data, CT1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick(1);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        tick(1);
        check("bp_no_latched_req", 64'(bus.busy), 64'd0);

`ifdef DES_DECRYPT_EN
        offer(CT1, KEY1, 1'b1);
        check("dec_fk_r1", 64'(bus.f_k), K16);
        tick(16);
        check("dec_out_valid", 64'(bus.out_valid), 64'd1);
        check("dec_out_data", bus.out_data, PT1);
`else
        offer(PT1, KEY1, 1'b1);
        check("nodec_fk_r1", 64'(bus.f_k), K1);
        tick(16);
        check("nodec_out_valid", 64'(bus.out_valid), 64'd1);
        check("nodec_out_data", bus.out_data, CT1);
`endif
        tick(1);
        check("mode_done_idle", 64'(bus.in_ready), 64'd1);

        // Back-to-back: request held high, second block accepted 18 cycles after the first.
        bus.in_valid   = 1'b1;
        bus.in_data    = PT1;
        bus.in_key     = KEY1;
        bus.in_decrypt = 1'b0;
        tick(1);
        bus.in_data = PT2;
        bus.in_key  = KEY2;
        tick(16);
        check("b2b_a_out_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_a_out_data", bus.out_data, CT1);
        tick(1);
        check("b2b_gap_in_ready", 64'(bus.in_ready), 64'd1);
        tick(1);
        check("b2b_b_busy", 64'(bus.busy), 64'd1);
        bus.in_valid = 1'b0;
        tick(16);
        check("b2b_b_out_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_b_out_data", bus.out_data, CT2);
        tick(1);
        check("b2b_end_busy", 64'(bus.busy), 64'd0);

        // Reset during round 7 drops the block; the next block is unaffected.
        offer(PT1, KEY1, 1'b0);
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_out_data", bus.out_data, 64'd0);
        offer(PT1, KEY1, 1'b0);
        tick(16);
        check("postrst_out_data", bus.out_data, CT1);
        tick(1);

        // Reset and request on the same edge: nothing accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = PT1;
        bus.in_key   = KEY1;
        rst          = 1'b1;
        tick(1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_vs_valid_busy", 64'(bus.busy), 64'd0);
        tick(1);
        check("rst_vs_valid_still_idle", 64'(bus.in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
